// File: rtl/uart_pkg.sv
// Shared TAP constants and the read router state encoding.
package uart_pkg;

    localparam int unsigned IRLENGTH = 5;

    localparam logic [IRLENGTH-1:0] ADDR_IDCODE  = 5'h01;
    localparam logic [IRLENGTH-1:0] ADDR_DTMCS   = 5'h10;
    localparam logic [IRLENGTH-1:0] ADDR_DMI     = 5'h11;
    localparam logic [IRLENGTH-1:0] ADDR_STB0_CS = 5'h12;
    localparam logic [IRLENGTH-1:0] ADDR_STB1_CS = 5'h13;
    localparam logic [IRLENGTH-1:0] ADDR_STB0_D  = 5'h14;
    localparam logic [IRLENGTH-1:0] ADDR_STB1_D  = 5'h15;
    localparam logic [IRLENGTH-1:0] ADDR_NOP     = 5'h1F;

    localparam logic [31:0] IDCODEVALUE   = 32'h1000_0CDB;
    localparam logic [31:0] DTMCS_DEFAULT = 32'h0000_5071;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } read_state_e;

endpackage

// File: rtl/rr_select.sv
// Rotating-priority selector: first set request at or after start_i, wrapping.
module rr_select #(
    parameter int unsigned N = 5,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] pos;

    // Walk the request vector from the start pointer and grant the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int k = 0; k < int'(N); k++) begin
            pos = IW'((int'(start_i) + k) % int'(N));
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule

// File: rtl/tap_read_router.sv
// Read-side router between the TAP read arbiter and the peripheral read channels.
module tap_read_router
    import uart_pkg::*;
#(
    parameter int unsigned                 NUM_CH     = 5,
    parameter int unsigned                 READ_WIDTH = 41,
    parameter logic [NUM_CH*IRLENGTH-1:0]  CH_ADDR    = {ADDR_STB1_D, ADDR_STB0_D, ADDR_STB1_CS,
                                                         ADDR_STB0_CS, ADDR_DMI},
    parameter bit                          RR_MODE    = 1'b1,
    parameter int unsigned                 TIMEOUT    = 0
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    input  logic                          READ_REQ_I,
    input  logic [IRLENGTH-1:0]           READ_ADDRESS_I,
    output logic [READ_WIDTH-1:0]         READ_DATA_O,
    output logic                          READ_VALID_O,
    input  logic                          READ_READY_I,
    output logic                          READ_ERR_O,
    output logic [IRLENGTH-1:0]           VALID_ADDRESS_O,
    input  logic [NUM_CH-1:0]             CH_VALID_I,
    output logic [NUM_CH-1:0]             CH_READY_O,
    input  logic [NUM_CH*READ_WIDTH-1:0]  CH_DATA_I
);

    localparam int unsigned IW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("tap_read_router: NUM_CH must be in 1..16");
    end
    if (READ_WIDTH < $bits(IDCODEVALUE)) begin : g_bad_width
        $error("tap_read_router: READ_WIDTH narrower than IDCODEVALUE");
    end

    read_state_e            state_q, state_d;
    logic [IRLENGTH-1:0]    addr_q, addr_d;
    logic [READ_WIDTH-1:0]  data_q, data_d;
    logic                   err_q, err_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IRLENGTH-1:0]    va_q, va_d;

    logic                   ch_hit;
    logic [IW-1:0]          ch_idx;
    logic [NUM_CH-1:0]      sel_gnt;
    logic [IW-1:0]          sel_idx;
    logic                   sel_any;
    logic [IW-1:0]          sel_start;

    // Address decode of the latched request; lowest channel wins on duplicates.
    always_comb begin
        ch_hit = 1'b0;
        ch_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (addr_q == CH_ADDR[i*IRLENGTH +: IRLENGTH]) begin
                ch_hit = 1'b1;
                ch_idx = IW'(i);
            end
        end
    end

    // Channel ready depends only on registered state, never on inputs.
    always_comb begin
        CH_READY_O = '0;
        if (state_q == FETCH && ch_hit) begin
            CH_READY_O[ch_idx] = 1'b1;
        end
    end

    // Next-state and datapath loads for the request/fetch/hold sequence.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (READ_REQ_I) begin
                    addr_d  = READ_ADDRESS_I;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (ch_hit) begin
                    if (CH_VALID_I[ch_idx]) begin
                        data_d   = CH_DATA_I[ch_idx*READ_WIDTH +: READ_WIDTH];
                        err_d    = 1'b0;
                        state_d  = DONE;
                        rr_ptr_d = (ch_idx == IW'(NUM_CH - 1)) ? '0 : ch_idx + 1'b1;
                    end else if (TIMEOUT != 0 && cnt_q == CNT_W'(TIMEOUT)) begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (addr_q == ADDR_IDCODE) begin
                    data_d  = READ_WIDTH'(IDCODEVALUE);
                    err_d   = 1'b0;
                    state_d = DONE;
                end else if (addr_q == ADDR_DTMCS) begin
                    data_d  = READ_WIDTH'(DTMCS_DEFAULT);
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (READ_READY_I) begin
                    if (READ_REQ_I) begin
                        addr_d  = READ_ADDRESS_I;
                        cnt_d   = '0;
                        state_d = FETCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending-channel selection; fixed priority pins the search start at 0.
    assign sel_start = RR_MODE ? rr_ptr_q : '0;

    rr_select #(.N(NUM_CH)) u_rr_select (
        .req_i   (CH_VALID_I),
        .start_i (sel_start),
        .gnt_o   (sel_gnt),
        .idx_o   (sel_idx),
        .any_o   (sel_any)
    );

    // Reported address of the selected pending channel, NOP when none pending.
    assign va_d = sel_any ? CH_ADDR[sel_idx*IRLENGTH +: IRLENGTH] : ADDR_NOP;

    // Grant vector and index must describe the same channel.
    a_sel_consistent: assert property (@(posedge CLK_I) disable iff (RST_I)
        sel_gnt == (sel_any ? (NUM_CH'(1) << sel_idx) : NUM_CH'(0)));

    // State register.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latched address, output stage, timer, pointer.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            addr_q   <= ADDR_NOP;
            data_q   <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            va_q     <= ADDR_NOP;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            va_q     <= va_d;
        end
    end

    assign READ_DATA_O     = data_q;
    assign READ_ERR_O      = err_q;
    assign READ_VALID_O    = (state_q == DONE);
    assign VALID_ADDRESS_O = va_q;

endmodule

// File: tb/tb_tap_read_router.sv
// Directed bench for tap_read_router: round-robin/timeout instance plus a fixed-priority instance.
module tb_tap_read_router;
    import uart_pkg::*;

    localparam int unsigned NCH = 5;
    localparam int unsigned RW  = 41;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 req;
    logic [IRLENGTH-1:0]  addr;
    logic                 ready;
    logic [NCH-1:0]       ch_valid;
    logic [NCH*RW-1:0]    ch_data;

    logic [RW-1:0]        rd_data, fp_rd_data;
    logic                 rd_valid, fp_rd_valid;
    logic                 rd_err, fp_rd_err;
    logic [IRLENGTH-1:0]  va, fp_va;
    logic [NCH-1:0]       ch_ready, fp_ch_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tap_read_router #(.NUM_CH(NCH), .READ_WIDTH(RW), .RR_MODE(1'b1), .TIMEOUT(8)) dut (
        .CLK_I(clk), .RST_I(rst), .READ_REQ_I(req), .READ_ADDRESS_I(addr),
        .READ_DATA_O(rd_data), .READ_VALID_O(rd_valid), .READ_READY_I(ready),
        .READ_ERR_O(rd_err), .VALID_ADDRESS_O(va), .CH_VALID_I(ch_valid),
        .CH_READY_O(ch_ready), .CH_DATA_I(ch_data)
    );

    tap_read_router #(.NUM_CH(NCH), .READ_WIDTH(RW), .RR_MODE(1'b0), .TIMEOUT(0)) dut_fp (
        .CLK_I(clk), .RST_I(rst), .READ_REQ_I(req), .READ_ADDRESS_I(addr),
        .READ_DATA_O(fp_rd_data), .READ_VALID_O(fp_rd_valid), .READ_READY_I(ready),
        .READ_ERR_O(fp_rd_err), .VALID_ADDRESS_O(fp_va), .CH_VALID_I(ch_valid),
        .CH_READY_O(fp_ch_ready), .CH_DATA_I(ch_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; ready = 1'b0; ch_valid = '0; addr = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic accept();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        req = 1'b1; addr = ADDR_DMI;
        tick();
        req = 1'b0;
        checks++; if (ch_ready !== 5'b00001) begin failures++; $display("FAIL rst_pre_ready got=%b exp=00001", ch_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", rd_err); end
        checks++; if (rd_data !== 41'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", rd_data); end
        checks++; if (ch_ready !== 5'b00000) begin failures++; $display("FAIL rst_ch_ready got=%b exp=00000", ch_ready); end
        checks++; if (va !== 5'h1F) begin failures++; $display("FAIL rst_va got=%h exp=1f", va); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_post_valid got=%b exp=0", rd_valid); end
        checks++; if (va !== 5'h1F) begin failures++; $display("FAIL rst_post_va got=%h exp=1f", va); end
        checks++; if (ch_ready !== 5'b00000) begin failures++; $display("FAIL rst_post_ready got=%b exp=00000", ch_ready); end
    endtask

    task automatic test_idcode();
        req = 1'b1; addr = ADDR_IDCODE;
        tick();
        req = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL idc_c1_valid got=%b exp=0", rd_valid); end
        checks++; if (ch_ready !== 5'b00000) begin failures++; $display("FAIL idc_c1_ready got=%b exp=00000", ch_ready); end
        tick();
        for (int c = 0; c < 6; c++) begin
            checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL idc_valid[%0d] got=%b exp=1", c, rd_valid); end
            checks++; if (rd_data !== 41'h000_1000_0CDB) begin failures++; $display("FAIL idc_data[%0d] got=%h exp=00010000cdb", c, rd_data); end
            checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL idc_err[%0d] got=%b exp=0", c, rd_err); end
            checks++; if (ch_ready !== 5'b00000) begin failures++; $display("FAIL idc_ready[%0d] got=%b exp=00000", c, ch_ready); end
            if (c < 5) tick();
        end
        accept();
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL idc_release got=%b exp=0", rd_valid); end
    endtask

    task automatic test_dmi();
        req = 1'b1; addr = ADDR_DMI;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (ch_ready !== 5'b00001) begin failures++; $display("FAIL dmi_ready[%0d] got=%b exp=00001", c, ch_ready); end
            checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL dmi_early_valid[%0d] got=%b exp=0", c, rd_valid); end
            if (c == 4) begin
                ch_valid[0] = 1'b1;
                ch_data[0*RW +: RW] = 41'h1_2345_6789A;
            end else begin
                tick();
            end
        end
        tick();
        ch_valid = '0;
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL dmi_valid got=%b exp=1", rd_valid); end
        checks++; if (rd_data !== 41'h1_2345_6789A) begin failures++; $display("FAIL dmi_data got=%h exp=123456789a", rd_data); end
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL dmi_err got=%b exp=0", rd_err); end
        checks++; if (ch_ready !== 5'b00000) begin failures++; $display("FAIL dmi_ready_done got=%b exp=00000", ch_ready); end
        accept();
    endtask

    task automatic test_timeout();
        req = 1'b1; addr = ADDR_STB0_D;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL to_early_valid[%0d] got=%b exp=0", c, rd_valid); end
            tick();
        end
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL to_valid got=%b exp=1", rd_valid); end
        checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL to_err got=%b exp=1", rd_err); end
        checks++; if (rd_data !== 41'h0) begin failures++; $display("FAIL to_data got=%h exp=0", rd_data); end
        accept();

        req = 1'b1; addr = ADDR_STB0_D;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL to_hs_early[%0d] got=%b exp=0", c, rd_valid); end
            if (c == 8) begin
                checks++; if (ch_ready !== 5'b01000) begin failures++; $display("FAIL to_hs_ready got=%b exp=01000", ch_ready); end
                ch_valid[3] = 1'b1;
                ch_data[3*RW +: RW] = 41'h0AB_CDEF_0123;
            end else begin
                tick();
            end
        end
        tick();
        ch_valid = '0;
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL to_hs_valid got=%b exp=1", rd_valid); end
        checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL to_hs_err got=%b exp=0", rd_err); end
        checks++; if (rd_data !== 41'h0AB_CDEF_0123) begin failures++; $display("FAIL to_hs_data got=%h exp=0abcdef0123", rd_data); end
        accept();
    endtask

    task automatic test_unmapped();
        req = 1'b1; addr = 5'h1F;
        tick();
        req = 1'b0;
        checks++; if (ch_ready !== 5'b00000) begin failures++; $display("FAIL unm_ready got=%b exp=00000", ch_ready); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL unm_early got=%b exp=0", rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL unm_valid got=%b exp=1", rd_valid); end
        checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL unm_err got=%b exp=1", rd_err); end
        checks++; if (rd_data !== 41'h0) begin failures++; $display("FAIL unm_data got=%h exp=0", rd_data); end
        checks++; if (ch_ready !== 5'b00000) begin failures++; $display("FAIL unm_ready_done got=%b exp=00000", ch_ready); end
        accept();
    endtask

    task automatic test_round_robin();
        logic [IRLENGTH-1:0] exp_addr [4];
        logic [RW-1:0]       exp_data [4];
        exp_addr = '{ADDR_DMI, ADDR_STB1_CS, ADDR_DMI, ADDR_STB1_CS};
        exp_data = '{41'h100, 41'h102, 41'h100, 41'h102};
        do_reset();
        for (int i = 0; i < int'(NCH); i++) ch_data[i*RW +: RW] = RW'(32'h100 + i);
        ch_valid = 5'b00101;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++; if (va !== exp_addr[k]) begin failures++; $display("FAIL rr_va[%0d] got=%h exp=%h", k, va, exp_addr[k]); end
            checks++; if (fp_va !== ADDR_DMI) begin failures++; $display("FAIL fp_va[%0d] got=%h exp=%h", k, fp_va, ADDR_DMI); end
            req = 1'b1; addr = exp_addr[k];
            tick();
            req = 1'b0;
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp_data[k]) begin
                failures++; $display("FAIL rr_read[%0d] got=%b/%h exp=1/%h", k, rd_valid, rd_data, exp_data[k]); end
            accept();
        end
        ch_valid = '0;
    endtask

    task automatic test_back_to_back();
        ch_data[0*RW +: RW] = 41'h155_5555_AAAA;
        ch_valid = 5'b00001;
        req = 1'b1; addr = ADDR_IDCODE;
        tick();
        req = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 41'h000_1000_0CDB) begin
            failures++; $display("FAIL b2b_idc got=%b/%h exp=1/00010000cdb", rd_valid, rd_data); end
        ready = 1'b1; req = 1'b1; addr = ADDR_DTMCS;
        tick();
        ready = 1'b0; req = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", rd_valid); end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 41'h000_0000_5071) begin
            failures++; $display("FAIL b2b_dtmcs got=%b/%h exp=1/00000005071", rd_valid, rd_data); end
        ready = 1'b1; req = 1'b1; addr = ADDR_DMI;
        tick();
        ready = 1'b0; req = 1'b0;
        checks++; if (ch_ready !== 5'b00001) begin failures++; $display("FAIL b2b_fetch got=%b exp=00001", ch_ready); end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 41'h155_5555_AAAA) begin
            failures++; $display("FAIL b2b_dmi got=%b/%h exp=1/1555555aaaa", rd_valid, rd_data); end
        ch_valid = '0;
        accept();
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; ready = 1'b0; ch_valid = '0; ch_data = '0;
        test_reset();
        test_idcode();
        test_dmi();
        test_timeout();
        test_unmapped();
        test_round_robin();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
